dsp_mac_sequencer: RTL and testbench

Time-multiplexed FIR controller that drives a single `test_dsp48` instance as its initiator. It accepts one sample per valid/ready handshake and stores it in a circular delay line. It then issues C_TAPS multiply/accumulate operations through the DSP operand and opmode ports, and waits out the DSP pipeline. Finally it rounds and saturates P and presents the result on a valid/ready output. It sits between the sample stream and the DSP48 wrapper; coefficients load through a simple write port.

---
 rtl/dsp_mac_sequencer_pkg.sv | 26 ++
 rtl/dsp_mac_sequencer_round_sat.sv | 40 ++++
 rtl/dsp_mac_sequencer.sv | 167 ++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared definitions for the time-multiplexed FIR sequencer: FSM encoding,
// DSP48 opmode constants per device family and the DSP pipeline latency.
package dsp_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [7:0] OP_V6_FIRST = 8'h05;
  localparam logic [7:0] OP_V6_ACC   = 8'h25;
  localparam logic [7:0] OP_S6_FIRST = 8'h01;
  localparam logic [7:0] OP_S6_ACC   = 8'h09;

  function automatic int f_lat(input int areg, input int mreg, input int preg);
    return areg + mreg + preg;
  endfunction

  function automatic logic [7:0] f_opmode(input bit is_s6, input bit acc);
    if (is_s6) return acc ? OP_S6_ACC : OP_S6_FIRST;
    return acc ? OP_V6_ACC : OP_V6_FIRST;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_round_sat.sv
// Registered round-half-up, arithmetic right shift and signed saturation of
// the 48-bit DSP accumulator down to C_OWIDTH bits.
module mac_round_sat #(
  parameter int C_OWIDTH = 18,
  parameter int C_SHIFT  = 17
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_load,
  input  logic [47:0]         I_p,
  output logic [C_OWIDTH-1:0] O_data
);

  localparam int                RSH  = (C_SHIFT == 0) ? 0 : C_SHIFT - 1;
  localparam logic signed [48:0] RND  = (C_SHIFT == 0) ? 49'sd0 : (49'sd1 <<< RSH);
  localparam logic signed [48:0] MAXV = (49'sd1 <<< (C_OWIDTH - 1)) - 49'sd1;
  localparam logic signed [48:0] MINV = -(49'sd1 <<< (C_OWIDTH - 1));

  logic signed [48:0]  w_sum;
  logic signed [48:0]  w_shr;
  logic [C_OWIDTH-1:0] w_sat;
  logic [C_OWIDTH-1:0] r_data;

  // One guard bit above P keeps the rounding add from wrapping.
  always_comb begin
    w_sum = 49'(signed'(I_p)) + RND;
    w_shr = w_sum >>> C_SHIFT;
    if (w_shr > MAXV)      w_sat = MAXV[C_OWIDTH-1:0];
    else if (w_shr < MINV) w_sat = MINV[C_OWIDTH-1:0];
    else                   w_sat = w_shr[C_OWIDTH-1:0];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)    r_data <= '0;
    else if (I_load) r_data <= w_sat;
  end

  assign O_data = r_data;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// FIR controller driving one DSP48 wrapper: accepts a sample, issues C_TAPS
// MACs, waits out the DSP pipeline, then presents a rounded/saturated result.
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter string C_DEVICE = "virtex6",
  parameter int    C_TAPS   = 8,
  parameter int    C_DWIDTH = 18,
  parameter int    C_CWIDTH = 18,
  parameter int    C_OWIDTH = 18,
  parameter int    C_SHIFT  = 17,
  parameter int    C_AREG   = 2,
  parameter int    C_MREG   = 1,
  parameter int    C_PREG   = 1
) (
  input  logic                        I_clk,
  input  logic                        I_rst_n,
  input  logic [C_DWIDTH-1:0]         I_data,
  input  logic                        I_valid,
  output logic                        O_ready,
  input  logic                        I_coef_we,
  input  logic [$clog2(C_TAPS)-1:0]   I_coef_addr,
  input  logic [C_CWIDTH-1:0]         I_coef_data,
  output logic [C_OWIDTH-1:0]         O_data,
  output logic                        O_valid,
  input  logic                        I_ready,
  output logic                        O_busy,
  output logic [29:0]                 O_dsp_a,
  output logic [17:0]                 O_dsp_b,
  output logic [7:0]                  O_dsp_opmode,
  output logic [3:0]                  O_dsp_aluctl,
  output logic [4:0]                  O_dsp_inmode,
  output logic                        O_dsp_rst,
  input  logic [47:0]                 I_dsp_p
);

  localparam int         AW       = $clog2(C_TAPS);
  localparam int         C_LAT    = f_lat(C_AREG, C_MREG, C_PREG);
  localparam int         CW       = $clog2(C_LAT + 1);
  localparam int         OP_DLY   = C_AREG + C_MREG - 1;
  localparam bit         IS_S6    = (C_DEVICE == "spartan6");
  localparam logic [7:0] OP_FIRST = f_opmode(IS_S6, 1'b0);
  localparam logic [7:0] OP_ACC   = f_opmode(IS_S6, 1'b1);

  state_e                     r_state;
  logic [AW-1:0]              r_k;
  logic [AW-1:0]              r_base;
  logic [AW-1:0]              r_wptr;
  logic [CW-1:0]              r_cnt;
  logic                       r_valid;
  logic [29:0]                r_a;
  logic [17:0]                r_b;
  logic [7:0]                 r_op;
  logic [1:0]                 r_rst_sync;
  logic signed [C_DWIDTH-1:0] r_delay [C_TAPS];
  logic signed [C_CWIDTH-1:0] r_coef  [C_TAPS];
  logic                       w_accept;
  logic                       w_capture;

  assign O_ready   = (r_state == ST_IDLE) && r_rst_sync[1];
  assign w_accept  = I_valid && O_ready;
  assign w_capture = (r_state == ST_DRAIN) && (r_cnt == CW'(C_LAT));

  // The DSP reset release is synchronised so the wrapper leaves reset cleanly.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_base  <= '0;
      r_wptr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_FIRST;
      for (int i = 0; i < C_TAPS; i++) begin
        r_delay[i] <= '0;
        r_coef[i]  <= '0;
      end
    end else begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= OP_FIRST;
      if (I_coef_we && (r_state == ST_IDLE)) r_coef[I_coef_addr] <= I_coef_data;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_delay[r_wptr] <= I_data;
            r_base          <= r_wptr;
            r_wptr          <= r_wptr + 1'b1;
            r_k             <= '0;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Tap k pairs coef[k] with the sample k positions older than the newest.
          r_a  <= 30'(r_coef[r_k]);
          r_b  <= 18'(r_delay[r_base - r_k]);
          r_op <= (r_k == '0) ? OP_FIRST : OP_ACC;
          r_k  <= r_k + 1'b1;
          if (r_k == AW'(C_TAPS - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_capture) begin
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (I_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Opmode lags the operands so it meets the product after the wrapper's OPMODEREG.
  generate
    if (OP_DLY == 0) begin : g_op_nodly
      assign O_dsp_opmode = r_op;
    end else begin : g_op_dly
      logic [7:0] r_op_dly [OP_DLY];
      always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
          for (int i = 0; i < OP_DLY; i++) r_op_dly[i] <= OP_FIRST;
        end else begin
          r_op_dly[0] <= r_op;
          for (int i = 1; i < OP_DLY; i++) r_op_dly[i] <= r_op_dly[i-1];
        end
      end
      assign O_dsp_opmode = r_op_dly[OP_DLY-1];
    end
  endgenerate

  mac_round_sat #(
    .C_OWIDTH (C_OWIDTH),
    .C_SHIFT  (C_SHIFT)
  ) u_round_sat (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_load  (w_capture),
    .I_p     (I_dsp_p),
    .O_data  (O_data)
  );

  assign O_valid      = r_valid;
  assign O_busy       = (r_state != ST_IDLE);
  assign O_dsp_a      = r_a;
  assign O_dsp_b      = r_b;
  assign O_dsp_aluctl = 4'd0;
  assign O_dsp_inmode = 5'd0;
  assign O_dsp_rst    = ~r_rst_sync[1];

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two instances (C_SHIFT 0 and 1) share stimulus,
// each driving a behavioural DSP48 (AREG=2, MREG=1, PREG=1, OPMODEREG=1).
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] i_data;
  logic        i_valid;
  logic        i_coef_we;
  logic [2:0]  i_coef_addr;
  logic [17:0] i_coef_data;
  logic        i_ready;

  logic [17:0] o_data  [2];
  logic        o_valid [2];
  logic        o_ready [2];
  logic        o_busy  [2];
  logic [29:0] dsp_a   [2];
  logic [17:0] dsp_b   [2];
  logic [7:0]  dsp_op  [2];
  logic [3:0]  dsp_alu [2];
  logic [4:0]  dsp_inm [2];
  logic        dsp_rst [2];
  logic [47:0] dsp_p   [2];

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0]        exp_q0[$];
  logic [17:0]        exp_q1[$];
  logic signed [17:0] m_coef [8];
  logic signed [17:0] m_hist [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_u
    dsp_mac_sequencer #(
      .C_DEVICE ("virtex6"), .C_TAPS (8), .C_DWIDTH (18), .C_CWIDTH (18),
      .C_OWIDTH (18), .C_SHIFT (g), .C_AREG (2), .C_MREG (1), .C_PREG (1)
    ) u_dut (
      .I_clk (clk), .I_rst_n (rst_n), .I_data (i_data), .I_valid (i_valid),
      .O_ready (o_ready[g]), .I_coef_we (i_coef_we), .I_coef_addr (i_coef_addr),
      .I_coef_data (i_coef_data), .O_data (o_data[g]), .O_valid (o_valid[g]),
      .I_ready (i_ready), .O_busy (o_busy[g]), .O_dsp_a (dsp_a[g]), .O_dsp_b (dsp_b[g]),
      .O_dsp_opmode (dsp_op[g]), .O_dsp_aluctl (dsp_alu[g]), .O_dsp_inmode (dsp_inm[g]),
      .O_dsp_rst (dsp_rst[g]), .I_dsp_p (dsp_p[g])
    );

    logic [29:0]        a_pipe [2];
    logic [17:0]        b_pipe [2];
    logic signed [47:0] m_r;
    logic signed [47:0] p_r;
    logic [7:0]         op_r;

    always @(posedge clk) begin
      if (dsp_rst[g]) begin
        a_pipe[0] <= '0; a_pipe[1] <= '0;
        b_pipe[0] <= '0; b_pipe[1] <= '0;
        m_r <= '0; p_r <= '0; op_r <= 8'h05;
      end else begin
        a_pipe[0] <= dsp_a[g]; a_pipe[1] <= a_pipe[0];
        b_pipe[0] <= dsp_b[g]; b_pipe[1] <= b_pipe[0];
        m_r  <= 48'($signed(a_pipe[1])) * 48'($signed(b_pipe[1]));
        op_r <= dsp_op[g];
        p_r  <= (op_r == 8'h25) ? p_r + m_r : m_r;
      end
    end
    assign dsp_p[g] = p_r;
  end

  task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [17:0] f_rs(input longint acc, input int sh);
    longint r;
    r = (sh == 0) ? acc : ((acc + (longint'(1) << (sh - 1))) >>> sh);
    if (r > 131071) r = 131071;
    else if (r < -131072) r = -131072;
    return 18'(r);
  endfunction

  task automatic model_accept(input logic signed [17:0] x);
    longint acc = 0;
    for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = x;
    for (int k = 0; k < 8; k++) acc += longint'(m_coef[k]) * longint'(m_hist[k]);
    exp_q0.push_back(f_rs(acc, 0));
    exp_q1.push_back(f_rs(acc, 1));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_coef[i] = '0;
      m_hist[i] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic write_coef(input int addr, input logic signed [17:0] v, input bit taken);
    @(negedge clk);
    i_coef_we = 1'b1; i_coef_addr = 3'(addr); i_coef_data = v;
    @(negedge clk);
    i_coef_we = 1'b0;
    if (taken) m_coef[addr] = v;
  endtask

  // Returns on the negedge right after the accepting posedge.
  task automatic send_sample(input logic signed [17:0] x);
    int n = 0;
    @(negedge clk);
    i_valid = 1'b1; i_data = x;
    while (!o_ready[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 48'(n), 48'(0));
    model_accept(x);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("valid_timeout", 48'(n), 48'(0));
  endtask

  task automatic recv(input string tag, output int lat);
    logic [17:0] e0, e1;
    wait_valid(lat);
    e0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : 18'h0;
    e1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : 18'h0;
    check({tag, "_s0"}, 48'(o_data[0]), 48'(e0));
    check({tag, "_s1"}, 48'(o_data[1]), 48'(e1));
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  48'(o_ready[0]), 48'(0));
    check({tag, "_valid"},  48'(o_valid[0]), 48'(0));
    check({tag, "_busy"},   48'(o_busy[0]),  48'(0));
    check({tag, "_data"},   48'(o_data[0]),  48'(0));
    check({tag, "_dsp_a"},  48'(dsp_a[0]),   48'(0));
    check({tag, "_dsp_b"},  48'(dsp_b[0]),   48'(0));
    check({tag, "_opmode"}, 48'(dsp_op[0]),  48'(8'h05));
    check({tag, "_dsprst"}, 48'(dsp_rst[0]), 48'(1));
  endtask

  task automatic release_reset(input string tag);
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (!o_ready[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_cycles"}, 48'(n), 48'(2));
    check({tag, "_dsprst_low"},   48'(dsp_rst[0]), 48'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    logic [17:0] hold_exp;
    rst_n = 1'b1; i_data = '0; i_valid = 1'b0; i_ready = 1'b0;
    i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0;
    model_clear();
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    check("por_aluctl", 48'(dsp_alu[0]), 48'(0));
    check("por_inmode", 48'(dsp_inm[0]), 48'(0));
    repeat (2) @(negedge clk);
    release_reset("por");

    // Impulse response reads back the coefficients in tap order.
    for (int k = 0; k < 8; k++) write_coef(k, 18'(k + 1), 1'b1);
    for (int i = 0; i < 9; i++) begin
      send_sample((i == 0) ? 18'sd1 : 18'sd0);
      recv("impulse", lat);
      if (i == 0) check("latency", 48'(lat), 48'(13));
    end

    // Saturation, positive then negative.
    for (int k = 0; k < 8; k++) write_coef(k, 18'sd131071, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_sample(18'sd131071);
      recv("sat_pos", lat);
    end
    for (int i = 0; i < 8; i++) begin
      send_sample(-18'sd131072);
      recv("sat_neg", lat);
    end

    // Rounding with a single unit tap.
    write_coef(0, 18'sd1, 1'b1);
    for (int k = 1; k < 8; k++) write_coef(k, 18'sd0, 1'b1);
    send_sample(18'sd3);
    recv("round_p3", lat);
    send_sample(-18'sd3);
    recv("round_m3", lat);

    // Coefficient write while busy is dropped; in IDLE it lands.
    send_sample(18'sd10);
    check("busy_in_issue", 48'(o_busy[0]), 48'(1));
    write_coef(0, 18'sd5, 1'b0);
    recv("coef_busy", lat);
    write_coef(0, 18'sd5, 1'b1);
    send_sample(18'sd10);
    recv("coef_idle", lat);

    // Backpressure: 20 stalled cycles with a competing sample offered.
    send_sample(18'sd7);
    wait_valid(lat);
    hold_exp = exp_q0[0];
    i_valid = 1'b1; i_data = -18'sd7;
    for (int c = 0; c < 20; c++) begin
      check("bp_valid", 48'(o_valid[0]), 48'(1));
      check("bp_ready", 48'(o_ready[0]), 48'(0));
      check("bp_data",  48'(o_data[0]),  48'(hold_exp));
      @(negedge clk);
    end
    void'(exp_q0.pop_front());
    void'(exp_q1.pop_front());
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("bp_ready_next", 48'(o_ready[0]), 48'(1));
    model_accept(-18'sd7);
    @(negedge clk);
    i_valid = 1'b0;
    check("bp_accepted", 48'(o_busy[0]), 48'(1));
    recv("bp_next", lat);

    // Random coefficients and samples.
    for (int k = 0; k < 8; k++) write_coef(k, 18'($urandom_range(200) - 100), 1'b1);
    for (int i = 0; i < 10; i++) begin
      send_sample(18'($urandom_range(200) - 100));
      recv("random", lat);
    end

    // Reset in the middle of DRAIN discards the result and clears coefficients.
    send_sample(18'sd1);
    repeat (10) @(negedge clk);
    check("drain_busy", 48'(o_busy[0]), 48'(1));
    rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    model_clear();
    repeat (3) @(negedge clk);
    release_reset("mid");
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_valid[0] || o_valid[1]) seen++;
      @(negedge clk);
    end
    check("mid_no_valid", 48'(seen), 48'(0));
    send_sample(18'sd1);
    recv("post_rst_impulse", lat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
